// File: rtl/rp_reconfig_sequencer.sv
// Partial-reconfiguration sequencer for one RP behind the valid/ready stream boundary.
// It gates upstream traffic, drains in-flight beats, decouples the RP, runs the PR loader, resets the RP and releases it.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | RP in service, waiting for reconfig_req
// GATE       | upstream gated, waiting for in-flight beats to drain
// DECOUPLE   | RP isolated, single-cycle pr_start to the loader
// WAIT_PR    | loader running, waiting for pr_done / pr_error / timeout
// RP_RESET   | fresh RP logic held in reset for RP_RST_CYCLES cycles
// RELEASE    | reset dropped, RP still isolated for one settling cycle
// FAULT      | load failed; RP isolated and held in reset until a retry
module rp_reconfig_sequencer #(
    parameter int CNT_W         = 8,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int PR_TIMEOUT    = 4096,
    parameter int RP_RST_CYCLES = 8,
    parameter int TMR_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reconfig_req,
    input  logic             in_fire,
    input  logic             out_fire,
    input  logic             pr_done,
    input  logic             pr_error,
    output logic             pr_start,
    output logic             gate_in,
    output logic             decouple,
    output logic             rp_rst,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] outstanding
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_DECOUPLE,
        S_WAIT_PR,
        S_RP_RESET,
        S_RELEASE,
        S_FAULT
    } state_t;

    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] PR_LAST    = TMR_W'(PR_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] RST_LAST   = TMR_W'(RP_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    localparam logic [1:0] EC_NONE    = 2'b00;
    localparam logic [1:0] EC_DRAIN   = 2'b01;
    localparam logic [1:0] EC_PR_ERR  = 2'b10;
    localparam logic [1:0] EC_PR_TOUT = 2'b11;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [1:0]       err_code_nxt;
    logic             error_nxt;
    logic             done_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            outstanding <= '0;
            err_code    <= EC_NONE;
            error       <= 1'b0;
            done        <= 1'b0;
            pr_start    <= 1'b0;
            gate_in     <= 1'b0;
            decouple    <= 1'b0;
            rp_rst      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            outstanding <= outstanding_nxt;
            err_code    <= err_code_nxt;
            error       <= error_nxt;
            done        <= done_nxt;
            // Outputs are decoded from the next state so they line up with the state register.
            pr_start    <= (state_nxt == S_DECOUPLE);
            gate_in     <= (state_nxt != S_IDLE);
            decouple    <= (state_nxt inside {S_DECOUPLE, S_WAIT_PR, S_RP_RESET, S_RELEASE, S_FAULT});
            rp_rst      <= (state_nxt inside {S_RP_RESET, S_FAULT});
            busy        <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt    = state;
        err_code_nxt = err_code;
        error_nxt    = 1'b0;
        done_nxt     = 1'b0;
        timer_nxt    = timer;

        case (state)
            S_IDLE: begin
                if (reconfig_req) begin
                    state_nxt    = S_GATE;
                    err_code_nxt = EC_NONE;
                end
            end
            S_GATE: begin
                if (outstanding == '0) begin
                    state_nxt = S_DECOUPLE;
                end else if (timer == DRAIN_LAST) begin
                    // Give up on draining; the old RP keeps serving traffic.
                    state_nxt    = S_IDLE;
                    error_nxt    = 1'b1;
                    err_code_nxt = EC_DRAIN;
                end
            end
            S_DECOUPLE: begin
                state_nxt = S_WAIT_PR;
            end
            S_WAIT_PR: begin
                if (pr_error) begin
                    state_nxt    = S_FAULT;
                    error_nxt    = 1'b1;
                    err_code_nxt = EC_PR_ERR;
                end else if (pr_done) begin
                    state_nxt = S_RP_RESET;
                end else if (timer == PR_LAST) begin
                    state_nxt    = S_FAULT;
                    error_nxt    = 1'b1;
                    err_code_nxt = EC_PR_TOUT;
                end
            end
            S_RP_RESET: begin
                if (timer == RST_LAST) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
                done_nxt  = 1'b1;
            end
            S_FAULT: begin
                // Retry skips the drain: the RP has been isolated since the failed load.
                if (reconfig_req) begin
                    state_nxt    = S_DECOUPLE;
                    err_code_nxt = EC_NONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (state_nxt != state) begin
            timer_nxt = '0;
        end else if (state inside {S_GATE, S_WAIT_PR, S_RP_RESET}) begin
            timer_nxt = timer + 1'b1;
        end
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({in_fire, out_fire})
            2'b10: if (outstanding != CNT_MAX) outstanding_nxt = outstanding + 1'b1;
            2'b01: if (outstanding != '0)      outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
    end

endmodule

// File: tb/tb_rp_reconfig_sequencer.sv
// Bench for rp_reconfig_sequencer: per-cycle stimulus with expected outputs queued at drive time
// and compared one cycle later, a vector table for the nominal flow plus hand-written corner sequences.
module tb_rp_reconfig_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_GATE  = 1;
    localparam int P_DEC   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_RPR   = 4;
    localparam int P_REL   = 5;
    localparam int P_FAULT = 6;

    typedef struct packed {
        logic rst;
        logic req;
        logic in_f;
        logic out_f;
        logic pd;
        logic pe;
    } ins_t;

    typedef struct packed {
        logic       pr_start;
        logic       gate_in;
        logic       decouple;
        logic       rp_rst;
        logic       busy;
        logic       done;
        logic       error;
        logic [1:0] err_code;
        logic [7:0] outstanding;
    } outs_t;

    typedef struct {
        ins_t  i;
        outs_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, reconfig_req, in_fire, out_fire, pr_done, pr_error;
    logic       pr_start, gate_in, decouple, rp_rst, busy, done, error;
    logic [1:0] err_code;
    logic [7:0] outstanding;

    int    errors = 0;
    int    checks = 0;
    outs_t sb[$];
    vec_t  t1[18];

    localparam ins_t NONE = '0;

    rp_reconfig_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .reconfig_req (reconfig_req),
        .in_fire      (in_fire),
        .out_fire     (out_fire),
        .pr_done      (pr_done),
        .pr_error     (pr_error),
        .pr_start     (pr_start),
        .gate_in      (gate_in),
        .decouple     (decouple),
        .rp_rst       (rp_rst),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .outstanding  (outstanding)
    );

    always #5 clk = ~clk;

    function automatic ins_t mi(input bit r, input bit rq, input bit inf, input bit outf,
                                input bit pd, input bit pe);
        ins_t v;
        v.rst = r; v.req = rq; v.in_f = inf; v.out_f = outf; v.pd = pd; v.pe = pe;
        return v;
    endfunction

    // Expected outputs from the spec's per-state gate/decouple/rp_rst table.
    function automatic outs_t ex(input int ph, input bit ps, input bit dn, input bit er,
                                 input logic [1:0] code, input int n);
        outs_t o;
        o = '0;
        case (ph)
            P_GATE:                begin o.gate_in = 1; o.busy = 1; end
            P_DEC, P_WAIT, P_REL:  begin o.gate_in = 1; o.decouple = 1; o.busy = 1; end
            P_RPR, P_FAULT:        begin o.gate_in = 1; o.decouple = 1; o.rp_rst = 1; o.busy = 1; end
            default: ;
        endcase
        o.pr_start    = ps;
        o.done        = dn;
        o.error       = er;
        o.err_code    = code;
        o.outstanding = 8'(n);
        return o;
    endfunction

    task automatic apply(input ins_t i, input outs_t e, input string nm);
        outs_t got, exp_o;
        rst = i.rst; reconfig_req = i.req; in_fire = i.in_f;
        out_fire = i.out_f; pr_done = i.pd; pr_error = i.pe;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got.pr_start = pr_start; got.gate_in = gate_in; got.decouple = decouple;
        got.rp_rst = rp_rst; got.busy = busy; got.done = done; got.error = error;
        got.err_code = err_code; got.outstanding = outstanding;
        exp_o = sb.pop_front();
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL %s: got ps=%b gate=%b dec=%b rprst=%b busy=%b done=%b err=%b code=%b n=%0d | exp ps=%b gate=%b dec=%b rprst=%b busy=%b done=%b err=%b code=%b n=%0d",
                     nm, got.pr_start, got.gate_in, got.decouple, got.rp_rst, got.busy, got.done,
                     got.error, got.err_code, got.outstanding, exp_o.pr_start, exp_o.gate_in,
                     exp_o.decouple, exp_o.rp_rst, exp_o.busy, exp_o.done, exp_o.error,
                     exp_o.err_code, exp_o.outstanding);
        end
    endtask

    // Called after the first RP_RESET cycle has been checked.
    task automatic tail(input string nm, input int n);
        for (int k = 0; k < 7; k++) apply(NONE, ex(P_RPR, 0, 0, 0, 2'b00, n), {nm, "_rprst"});
        apply(NONE, ex(P_REL,  0, 0, 0, 2'b00, n), {nm, "_release"});
        apply(NONE, ex(P_IDLE, 0, 1, 0, 2'b00, n), {nm, "_done"});
        apply(NONE, ex(P_IDLE, 0, 0, 0, 2'b00, n), {nm, "_idle"});
    endtask

    initial begin
        rst = 1; reconfig_req = 0; in_fire = 0; out_fire = 0; pr_done = 0; pr_error = 0;

        // Nominal flow: req at cycle 0, pr_done 5 cycles after pr_start.
        t1[0] = '{mi(0,1,0,0,0,0), ex(P_GATE, 0,0,0,2'b00,0)};
        t1[1] = '{NONE,            ex(P_DEC,  1,0,0,2'b00,0)};
        for (int k = 2; k <= 6; k++) t1[k] = '{NONE, ex(P_WAIT, 0,0,0,2'b00,0)};
        t1[7] = '{mi(0,0,0,0,1,0), ex(P_RPR,  0,0,0,2'b00,0)};
        for (int k = 8; k <= 14; k++) t1[k] = '{NONE, ex(P_RPR, 0,0,0,2'b00,0)};
        t1[15] = '{NONE, ex(P_REL,  0,0,0,2'b00,0)};
        t1[16] = '{NONE, ex(P_IDLE, 0,1,0,2'b00,0)};
        t1[17] = '{NONE, ex(P_IDLE, 0,0,0,2'b00,0)};

        repeat (2) @(posedge clk);
        #1;
        apply(mi(1,1,1,0,0,0), ex(P_IDLE,0,0,0,2'b00,0), "reset_hold");
        apply(NONE,            ex(P_IDLE,0,0,0,2'b00,0), "post_reset");

        for (int k = 0; k < 18; k++) apply(t1[k].i, t1[k].o, $sformatf("nominal_%0d", k));

        // Three beats in flight: stay in GATE until drained.
        for (int k = 0; k < 3; k++) apply(mi(0,0,1,0,0,0), ex(P_IDLE,0,0,0,2'b00,k+1), "fill3");
        apply(mi(0,1,0,0,0,0), ex(P_GATE,0,0,0,2'b00,3), "drain_gate");
        apply(NONE,            ex(P_GATE,0,0,0,2'b00,3), "drain_hold");
        for (int k = 0; k < 3; k++) apply(mi(0,0,0,1,0,0), ex(P_GATE,0,0,0,2'b00,2-k), "drain_out");
        apply(NONE,            ex(P_DEC, 1,0,0,2'b00,0), "drain_decouple");
        apply(NONE,            ex(P_WAIT,0,0,0,2'b00,0), "drain_wait");
        apply(mi(0,0,0,0,1,0), ex(P_RPR, 0,0,0,2'b00,0), "drain_rpr");
        tail("drain", 0);

        // Stuck pipe: 64 GATE cycles then drain timeout.
        for (int k = 0; k < 2; k++) apply(mi(0,0,1,0,0,0), ex(P_IDLE,0,0,0,2'b00,k+1), "stuck_fill");
        apply(mi(0,1,0,0,0,0), ex(P_GATE,0,0,0,2'b00,2), "stuck_gate");
        for (int k = 1; k < 64; k++) apply(NONE, ex(P_GATE,0,0,0,2'b00,2), "stuck_hold");
        apply(NONE, ex(P_IDLE,0,0,1,2'b01,2), "stuck_timeout");
        apply(NONE, ex(P_IDLE,0,0,0,2'b01,2), "stuck_after");
        apply(mi(0,0,0,1,0,0), ex(P_IDLE,0,0,0,2'b01,1), "stuck_drain1");
        apply(mi(0,0,0,1,0,0), ex(P_IDLE,0,0,0,2'b01,0), "stuck_drain0");

        // pr_error wins over pr_done, then retry from FAULT.
        apply(mi(0,1,0,0,0,0), ex(P_GATE, 0,0,0,2'b00,0), "prerr_gate");
        apply(NONE,            ex(P_DEC,  1,0,0,2'b00,0), "prerr_dec");
        apply(NONE,            ex(P_WAIT, 0,0,0,2'b00,0), "prerr_wait");
        apply(NONE,            ex(P_WAIT, 0,0,0,2'b00,0), "prerr_wait2");
        apply(mi(0,0,0,0,1,1), ex(P_FAULT,0,0,1,2'b10,0), "prerr_fault");
        apply(NONE,            ex(P_FAULT,0,0,0,2'b10,0), "prerr_hold");
        apply(mi(0,0,0,0,1,0), ex(P_FAULT,0,0,0,2'b10,0), "prerr_ignore_done");
        apply(mi(0,1,0,0,0,0), ex(P_DEC,  1,0,0,2'b00,0), "prerr_retry");
        apply(NONE,            ex(P_WAIT, 0,0,0,2'b00,0), "prerr_rewait");
        apply(mi(0,0,0,0,1,0), ex(P_RPR,  0,0,0,2'b00,0), "prerr_rpr");
        tail("prerr", 0);

        // PR timeout after 4096 WAIT_PR cycles.
        apply(mi(0,1,0,0,0,0), ex(P_GATE,0,0,0,2'b00,0), "prto_gate");
        apply(NONE,            ex(P_DEC, 1,0,0,2'b00,0), "prto_dec");
        apply(NONE,            ex(P_WAIT,0,0,0,2'b00,0), "prto_wait");
        for (int k = 1; k < 4096; k++) apply(NONE, ex(P_WAIT,0,0,0,2'b00,0), "prto_hold");
        apply(NONE,            ex(P_FAULT,0,0,1,2'b11,0), "prto_fault");
        apply(NONE,            ex(P_FAULT,0,0,0,2'b11,0), "prto_hold_fault");
        apply(mi(0,1,0,0,0,0), ex(P_DEC,  1,0,0,2'b00,0), "prto_retry");
        apply(NONE,            ex(P_WAIT, 0,0,0,2'b00,0), "prto_rewait");
        apply(mi(0,0,0,0,1,0), ex(P_RPR,  0,0,0,2'b00,0), "prto_rpr");
        tail("prto", 0);

        // Counter edges: simultaneous fire, low and high saturation.
        apply(mi(0,0,1,0,0,0), ex(P_IDLE,0,0,0,2'b00,1), "cnt_one");
        apply(mi(0,0,1,1,0,0), ex(P_IDLE,0,0,0,2'b00,1), "cnt_both");
        apply(mi(0,0,0,1,0,0), ex(P_IDLE,0,0,0,2'b00,0), "cnt_zero");
        apply(mi(0,0,0,1,0,0), ex(P_IDLE,0,0,0,2'b00,0), "cnt_sat_low");
        for (int k = 0; k < 256; k++)
            apply(mi(0,0,1,0,0,0), ex(P_IDLE,0,0,0,2'b00,(k < 255) ? k+1 : 255), "cnt_fill");
        apply(mi(0,0,1,1,0,0), ex(P_IDLE,0,0,0,2'b00,255), "cnt_both_max");
        for (int k = 0; k < 255; k++)
            apply(mi(0,0,0,1,0,0), ex(P_IDLE,0,0,0,2'b00,254-k), "cnt_drain");

        // Reset while RP is held in reset.
        apply(mi(0,1,0,0,0,0), ex(P_GATE,0,0,0,2'b00,0), "rst_gate");
        apply(NONE,            ex(P_DEC, 1,0,0,2'b00,0), "rst_dec");
        apply(NONE,            ex(P_WAIT,0,0,0,2'b00,0), "rst_wait");
        apply(mi(0,0,0,0,1,0), ex(P_RPR, 0,0,0,2'b00,0), "rst_rpr");
        apply(mi(0,0,1,0,0,0), ex(P_RPR, 0,0,0,2'b00,1), "rst_rpr_beat");
        apply(mi(1,0,0,0,0,0), ex(P_IDLE,0,0,0,2'b00,0), "rst_mid");
        apply(NONE,            ex(P_IDLE,0,0,0,2'b00,0), "rst_idle");
        apply(mi(0,1,0,0,0,0), ex(P_GATE,0,0,0,2'b00,0), "rst_restart");
        apply(NONE,            ex(P_DEC, 1,0,0,2'b00,0), "rst_restart_dec");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rp_reconfig_sequencer.md
Name: rp_reconfig_sequencer

Overview:
- Sequences a partial reconfiguration of one reconfigurable partition (RP) sitting behind the static↔RP valid/ready stream interface.
- Phases, in order:
  - gate new upstream traffic;
  - drain in-flight beats;
  - decouple the RP and start the PR loader;
  - wait for the load to finish;
  - hold the RP in reset;
  - release.
- Driven by the self-healing manager (reconfig_req). Drives the interface's gating/decouple muxes and the PR engine.

Parameters:
- CNT_W, 8: width of the outstanding-beat counter.
- DRAIN_TIMEOUT, 64: maximum cycles spent in GATE waiting for drain.
- PR_TIMEOUT, 4096: maximum cycles spent in WAIT_PR.
- RP_RST_CYCLES, 8: cycles rp_rst is held after a successful load (≥1).
- TMR_W, 16: width of the shared phase timer.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reconfig_req  in  1  level request from the health manager; sampled only in IDLE or FAULT
- in_fire  in  1  upstream beat accepted (in_valid & in_ready)
- out_fire  in  1  downstream beat delivered (out_valid & out_ready)
- pr_done  in  1  PR loader completed the bitstream (1-cycle pulse)
- pr_error  in  1  PR loader failure (CRC/ID; 1-cycle pulse)
- pr_start  out  1  1-cycle pulse to the PR loader
- gate_in  out  1  forces in_ready/rp_in_valid low at the interface
- decouple  out  1  isolates RP outputs (rp_out_valid masked, rp_out_ready forced 0)
- rp_rst  out  1  reset to the RP logic
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle pulse on successful completion
- error  out  1  1-cycle pulse on abort/fault entry
- err_code  out  2  00 none, 01 drain timeout, 10 PR error, 11 PR timeout
- outstanding  out  CNT_W  current in-flight beat count

Behaviour:
- Reset values:
  - state IDLE;
  - all 1-bit outputs 0;
  - err_code 00; outstanding 0; timer 0.
- All outputs are registered.
- Outstanding counter, updated every cycle in every state:
  - in_fire only: +1, saturating at 2^CNT_W−1.
  - out_fire only: −1, saturating at 0.
  - in_fire and out_fire together: unchanged.
  - The RP is 1 beat in → 1 beat out.
- States and outputs (gate/decouple/rp_rst):
  - IDLE 0/0/0
  - GATE 1/0/0
  - DECOUPLE 1/1/0
  - WAIT_PR 1/1/0
  - RP_RESET 1/1/1
  - RELEASE 1/1/0
  - FAULT 1/1/1
- IDLE:
  - reconfig_req=1 → GATE next cycle; err_code cleared to 00; timer cleared.
- GATE:
  - Registered outstanding==0 → DECOUPLE.
  - Otherwise timer increments. When timer reaches DRAIN_TIMEOUT−1 with outstanding≠0 → IDLE with error=1, err_code=01. The RP keeps running unreconfigured.
- DECOUPLE:
  - Lasts 1 cycle; pr_start=1 during it; → WAIT_PR; timer cleared.
- WAIT_PR:
  - pr_error → FAULT, err_code=10. If pr_error and pr_done are high in the same cycle, error wins.
  - Else pr_done → RP_RESET, timer cleared.
  - Else timer reaches PR_TIMEOUT−1 → FAULT, err_code=11.
  - error pulses on FAULT entry.
- RP_RESET:
  - Held exactly RP_RST_CYCLES cycles → RELEASE.
- RELEASE:
  - Lasts 1 cycle (rp_rst low, RP still isolated) → IDLE with done=1 on the first IDLE cycle.
- FAULT:
  - RP stays isolated and in reset; err_code holds.
  - reconfig_req=1 → DECOUPLE (retry load, no drain needed); err_code cleared.
- reconfig_req in any other state is ignored; no queuing.
- pr_done/pr_error outside WAIT_PR are ignored.
- Latency from req to done, with an empty pipe: 1 (GATE) + 1 (DECOUPLE) + N (WAIT_PR, until pr_done) + RP_RST_CYCLES + 1 (RELEASE), with done asserted on the following cycle.
- rst mid-sequence: next cycle IDLE, all outputs 0, counter 0.
  - Aborting the PR loader is the loader's own reset's job.

Test Plan:
- Idle pipe, defaults. reconfig_req at cycle 0; pr_done 5 cycles after pr_start → the following all hold:
  - gate_in rises at cycle 1;
  - decouple and pr_start at cycle 2;
  - rp_rst high for exactly 8 cycles;
  - done pulses once;
  - busy=0 afterwards; err_code=00.
- Three beats in flight (three in_fire pulses), then reconfig_req:
  - sequencer stays in GATE (decouple=0);
  - after three out_fire pulses, outstanding=0 and decouple rises the next cycle.
- Stuck pipe: outstanding=2, no out_fire, reconfig_req → after 64 GATE cycles: error pulse, err_code=01, gate_in=0, decouple never asserted, pr_start never pulsed.
- pr_error in WAIT_PR (pr_done high in the same cycle) → FAULT, err_code=10, rp_rst=1, decouple=1. Second reconfig_req → pr_start pulses again without GATE; pr_done → normal completion, err_code=00.
- No pr_done → after 4096 WAIT_PR cycles: FAULT, err_code=11.
- Edge cases:
  - simultaneous in_fire and out_fire with outstanding=1 → stays 1;
  - 256 in_fire pulses → saturates at 255;
  - rst asserted in RP_RESET → next cycle all outputs 0, state IDLE.
